// File: rtl/corner_tracker.sv
// Frame corner tracker: finds the TL/BL/BR/TR extreme hit pixels of a thresholded stream.
// Optional watchdog on ACCUM enabled by defining CORNER_TRACKER_TIMEOUT_EN (adds the timeout port).
module corner_tracker #(
    parameter int COORD_W        = 10,
    parameter int HIT_CNT_W      = 20,
    parameter int MIN_HITS       = 16,
    parameter int DEF_X0         = 192,
    parameter int DEF_X1         = 832,
    parameter int DEF_Y0         = 144,
    parameter int DEF_Y1         = 624,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   pix_valid,
    input  logic [COORD_W-1:0]     pix_x,
    input  logic [COORD_W-1:0]     pix_y,
    input  logic                   pix_hit,
    input  logic                   frame_end,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [HIT_CNT_W-1:0]   hit_count,
    output logic [8*COORD_W-1:0]   corners
`ifdef CORNER_TRACKER_TIMEOUT_EN
    ,
    output logic                   timeout
`endif
);

    localparam int SW = COORD_W + 1;

    localparam logic [COORD_W-1:0]   DX0 = COORD_W'(DEF_X0);
    localparam logic [COORD_W-1:0]   DX1 = COORD_W'(DEF_X1);
    localparam logic [COORD_W-1:0]   DY0 = COORD_W'(DEF_Y0);
    localparam logic [COORD_W-1:0]   DY1 = COORD_W'(DEF_Y1);
    localparam logic [8*COORD_W-1:0] DEF_CORNERS = {DX0, DY0, DX0, DY1, DX1, DY1, DX1, DY0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH1,
        S_FLUSH2,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_accept;
    logic w_hit;
    logic w_frame_end;
    logic w_publish;
    logic w_wd_expire;

    // Stage 1: sum/difference of the hit pixel.
    logic                  r_s1_valid;
    logic [SW-1:0]         r_s1_s;
    logic signed [SW-1:0]  r_s1_d;
    logic [COORD_W-1:0]    r_s1_x;
    logic [COORD_W-1:0]    r_s1_y;

    // Stage 2: running extrema and their coordinates.
    logic                  r_have;
    logic [SW-1:0]         r_min_s;
    logic [SW-1:0]         r_max_s;
    logic signed [SW-1:0]  r_min_d;
    logic signed [SW-1:0]  r_max_d;
    logic [COORD_W-1:0]    r_tl_x, r_tl_y;
    logic [COORD_W-1:0]    r_bl_x, r_bl_y;
    logic [COORD_W-1:0]    r_br_x, r_br_y;
    logic [COORD_W-1:0]    r_tr_x, r_tr_y;

    logic [HIT_CNT_W-1:0]  r_hit_cnt;

    logic                  r_done;
    logic                  r_found;
    logic [HIT_CNT_W-1:0]  r_hit_count;
    logic [8*COORD_W-1:0]  r_corners;

    // A start on the same beat overrides any pixel (including frame_end).
    assign w_accept    = (r_state == S_ACCUM) && pix_valid && !start;
    assign w_hit       = w_accept && pix_hit;
    assign w_frame_end = w_accept && frame_end;

`ifdef CORNER_TRACKER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd;
    logic            r_timeout;

    assign w_wd_expire = (r_state == S_ACCUM) && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (start || r_state != S_ACCUM)
                r_wd <= '0;
            else
                r_wd <= r_wd + 1'b1;

            if (start)
                r_timeout <= 1'b0;
            else if (w_publish && w_wd_expire)
                r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    // Watchdog compiled out; the limit is only meaningful when it exists.
    assign w_wd_expire = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        // NOTE: default first so every path assigns w_next; otherwise a latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_IDLE;
            S_ACCUM: begin
                if (w_frame_end)
                    w_next = S_FLUSH1;
                else if (w_wd_expire)
                    w_next = S_DONE;
            end
            S_FLUSH1: w_next = S_FLUSH2;
            S_FLUSH2: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (start)
            w_next = S_ACCUM;
    end

    assign w_publish = (w_next == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_s     <= '0;
            r_s1_d     <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_hit_cnt  <= '0;
        end else begin
            r_s1_valid <= w_hit;
            if (w_hit) begin
                r_s1_s <= {1'b0, pix_x} + {1'b0, pix_y};
                r_s1_d <= $signed({1'b0, pix_x}) - $signed({1'b0, pix_y});
                r_s1_x <= pix_x;
                r_s1_y <= pix_y;
            end
            if (start)
                r_hit_cnt <= '0;
            else if (w_hit && r_hit_cnt != '1)
                r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    // Strict compares keep the earliest pixel on ties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_have  <= 1'b0;
            r_min_s <= '0;
            r_max_s <= '0;
            r_min_d <= '0;
            r_max_d <= '0;
            r_tl_x  <= '0;
            r_tl_y  <= '0;
            r_bl_x  <= '0;
            r_bl_y  <= '0;
            r_br_x  <= '0;
            r_br_y  <= '0;
            r_tr_x  <= '0;
            r_tr_y  <= '0;
        end else if (start) begin
            r_have <= 1'b0;
        end else if (r_s1_valid) begin
            r_have <= 1'b1;
            if (!r_have || r_s1_s < r_min_s) begin
                r_min_s <= r_s1_s;
                r_tl_x  <= r_s1_x;
                r_tl_y  <= r_s1_y;
            end
            if (!r_have || r_s1_s > r_max_s) begin
                r_max_s <= r_s1_s;
                r_br_x  <= r_s1_x;
                r_br_y  <= r_s1_y;
            end
            if (!r_have || r_s1_d < r_min_d) begin
                r_min_d <= r_s1_d;
                r_bl_x  <= r_s1_x;
                r_bl_y  <= r_s1_y;
            end
            if (!r_have || r_s1_d > r_max_d) begin
                r_max_d <= r_s1_d;
                r_tr_x  <= r_s1_x;
                r_tr_y  <= r_s1_y;
            end
        end
    end

    // Published result changes only together with the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_hit_count <= '0;
            r_corners   <= DEF_CORNERS;
        end else begin
            r_done <= w_publish;
            if (w_publish) begin
                r_hit_count <= r_hit_cnt;
                if (!w_wd_expire && r_hit_cnt >= HIT_CNT_W'(MIN_HITS)) begin
                    r_found   <= 1'b1;
                    r_corners <= {r_tl_x, r_tl_y, r_bl_x, r_bl_y,
                                  r_br_x, r_br_y, r_tr_x, r_tr_y};
                end else begin
                    r_found   <= 1'b0;
                    r_corners <= DEF_CORNERS;
                end
            end
        end
    end

    assign busy      = (r_state == S_ACCUM) || (r_state == S_FLUSH1) || (r_state == S_FLUSH2);
    assign done      = r_done;
    assign found     = r_found;
    assign hit_count = r_hit_count;
    assign corners   = r_corners;

endmodule

// File: tb/tb_corner_tracker.sv
// Directed scoreboard bench for corner_tracker (default build, watchdog disabled).
module tb_corner_tracker;

    localparam int CW = 10;
    localparam int HW = 20;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            pix_valid;
    logic [CW-1:0]   pix_x;
    logic [CW-1:0]   pix_y;
    logic            pix_hit;
    logic            frame_end;
    logic            busy;
    logic            done;
    logic            found;
    logic [HW-1:0]   hit_count;
    logic [8*CW-1:0] corners;

    corner_tracker dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_hit   (pix_hit),
        .frame_end (frame_end),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .hit_count (hit_count),
        .corners   (corners)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8*CW-1:0] corners;
        logic            found;
        logic [HW-1:0]   cnt;
        int              cyc;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    int   n_done = 0;
    int   n_exp  = 0;
    int   errors = 0;
    int   checks = 0;

    logic [8*CW-1:0] def_corners;
    logic [8*CW-1:0] last_corners;

    // Reference model state for the frame in progress.
    int m_cnt, m_min_s, m_max_s, m_min_d, m_max_d;
    bit m_have;
    int m_tl_x, m_tl_y, m_bl_x, m_bl_y, m_br_x, m_br_y, m_tr_x, m_tr_y;

    always @(negedge clk) begin : mon
        res_t r;
        if (done) begin
            r.corners = corners;
            r.found   = found;
            r.cnt     = hit_count;
            r.cyc     = cyc;
            obs_q.push_back(r);
            n_done++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [8*CW-1:0] obs, input logic [8*CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_have = 0;
    endtask

    task automatic model_hit(input int x, input int y);
        int s, d;
        s = x + y;
        d = x - y;
        m_cnt++;
        if (!m_have || s < m_min_s) begin m_min_s = s; m_tl_x = x; m_tl_y = y; end
        if (!m_have || s > m_max_s) begin m_max_s = s; m_br_x = x; m_br_y = y; end
        if (!m_have || d < m_min_d) begin m_min_d = d; m_bl_x = x; m_bl_y = y; end
        if (!m_have || d > m_max_d) begin m_max_d = d; m_tr_x = x; m_tr_y = y; end
        m_have = 1;
    endtask

    task automatic push_expected();
        res_t e;
        e.found   = (m_cnt >= 16);
        e.cnt     = HW'(m_cnt);
        e.corners = e.found ? {CW'(m_tl_x), CW'(m_tl_y), CW'(m_bl_x), CW'(m_bl_y),
                               CW'(m_br_x), CW'(m_br_y), CW'(m_tr_x), CW'(m_tr_y)}
                            : def_corners;
        e.cyc     = cyc + 3;
        exp_q.push_back(e);
        n_exp++;
    endtask

    task automatic do_start();
        start = 1'b1;
        model_clear();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic beat(input int x, input int y, input bit hit, input bit fe);
        pix_valid = 1'b1;
        pix_x     = CW'(x);
        pix_y     = CW'(y);
        pix_hit   = hit;
        frame_end = fe;
        if (hit) model_hit(x, y);
        if (fe)  push_expected();
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_hit   = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic block4(input int x0, input int y0, input bit fe_last);
        for (int dy = 0; dy < 4; dy++)
            for (int dx = 0; dx < 4; dx++)
                beat(x0 + dx, y0 + dy, 1'b1, fe_last && dx == 3 && dy == 3);
    endtask

    task automatic wait_result(input string tag);
        res_t e, o;
        int k;
        k = 0;
        while (obs_q.size() == 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_done_seen"}, obs_q.size() != 0, 1'b1);
        if (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_done_cycle"}, o.cyc, e.cyc);
            check({tag, "_corners"},    o.corners, e.corners);
            check({tag, "_found"},      o.found, e.found);
            check({tag, "_hit_count"},  o.cnt, e.cnt);
            last_corners = e.corners;
        end
    endtask

    initial begin
        def_corners  = {10'd192, 10'd144, 10'd192, 10'd624, 10'd832, 10'd624, 10'd832, 10'd144};
        last_corners = def_corners;
        reset_n   = 1'b0;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        pix_hit   = 1'b0;
        frame_end = 1'b0;
        model_clear();

        // Reset values, then 20 idle cycles.
        #22;
        check("rst_corners",   corners, def_corners);
        check("rst_found",     found, 1'b0);
        check("rst_hit_count", hit_count, '0);
        check("rst_busy",      busy, 1'b0);
        check("rst_done",      done, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_no_done",  obs_q.size(), 0);
        check("idle_corners",  corners, def_corners);
        check("idle_found",    found, 1'b0);

        // Four 4x4 blocks, frame_end on the last hit.
        do_start();
        check("f1_busy", busy, 1'b1);
        block4(100, 50, 1'b0);
        beat(500, 500, 1'b0, 1'b0);
        block4(90, 400, 1'b0);
        block4(700, 420, 1'b0);
        block4(710, 60, 1'b1);
        check("f1_busy_flush", busy, 1'b1);
        wait_result("f1");

        // Five hits only: defaults published.
        do_start();
        check("f2_pub_hold", corners, last_corners);
        for (int i = 0; i < 5; i++) begin
            beat(300 + i * 7, 200 + i * 3, 1'b1, 1'b0);
            beat(10, 10, 1'b0, 1'b0);
        end
        beat(20, 20, 1'b0, 1'b1);
        wait_result("f2");

        // Tie on min s: (10,20) precedes (20,10).
        do_start();
        beat(10, 20, 1'b1, 1'b0);
        beat(20, 10, 1'b1, 1'b0);
        block4(300, 300, 1'b1);
        wait_result("f3");

        // Abandoned frame, start+frame_end collision, then the real frame.
        do_start();
        for (int i = 0; i < 8; i++) beat(400 + i, 200, 1'b1, 1'b0);
        do_start();
        for (int i = 0; i < 6; i++) beat(5 + i, 900, 1'b1, 1'b0);
        start = 1'b1; pix_valid = 1'b1; pix_hit = 1'b1; frame_end = 1'b1;
        pix_x = 10'd1; pix_y = 10'd1;
        model_clear();
        @(posedge clk); #1;
        start = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0; frame_end = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("collide_no_done", obs_q.size(), 0);
        block4(600, 100, 1'b0);
        block4(150, 700, 1'b1);
        wait_result("f4");

        // Asynchronous reset in mid-frame.
        do_start();
        for (int i = 0; i < 20; i++) beat(50 + i, 60 + i, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_corners",   corners, def_corners);
        check("arst_found",     found, 1'b0);
        check("arst_hit_count", hit_count, '0);
        check("arst_busy",      busy, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_clear();

        // Beats outside ACCUM are ignored.
        for (int i = 0; i < 4; i++) beat(30 + i, 30, 1'b1, i == 3);
        exp_q.delete();
        n_exp--;
        model_clear();
        repeat (8) @(posedge clk);
        #1;
        check("idle_beats_no_done", obs_q.size(), 0);
        check("done_total", n_done, n_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/corner_tracker.md
Name: corner_tracker

Overview:
- Parametrised successor to the fixed-output corner detector stub.
- Scans the thresholded pixel stream of one frame and locates the four extreme "hit" pixels: top-left, bottom-left, bottom-right and top-right.
- Publishes the result on the same packed corners bus, framed by a start/done handshake.
- Sits between the colour-threshold stage and the perspective/transform stage that consumes corners.

Parameters:
- COORD_W, 10, width of each x/y coordinate.
- HIT_CNT_W, 20, width of the hit counter (saturating).
- MIN_HITS, 16, minimum hit count for the result to be accepted.
- DEF_X0, 192, default left x.
- DEF_X1, 832, default right x.
- DEF_Y0, 144, default top y.
- DEF_Y1, 624, default bottom y.
- TIMEOUT_CYCLES, 2000000, watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins accumulation of a new frame.
- pix_valid  in  1  pixel beat qualifier.
- pix_x  in  COORD_W  pixel column.
- pix_y  in  COORD_W  pixel row.
- pix_hit  in  1  pixel passed the threshold.
- frame_end  in  1  marks the last pixel of the frame; qualified by pix_valid.
- busy  out  1  high in ACCUM and FLUSH.
- done  out  1  one-cycle pulse when the result is published.
- found  out  1  last result met MIN_HITS.
- hit_count  out  HIT_CNT_W  hits counted in the last completed frame.
- corners  out  8*COORD_W  packed, MSB first: TL.x, TL.y, BL.x, BL.y, BR.x, BR.y, TR.x, TR.y.

Behaviour:
- Reset values (reset_n low):
  - done=0, busy=0, found=0, hit_count=0.
  - corners = defaults: TL=(DEF_X0,DEF_Y0), BL=(DEF_X0,DEF_Y1), BR=(DEF_X1,DEF_Y1), TR=(DEF_X1,DEF_Y0).
  - FSM in IDLE.
- FSM states:
  - IDLE: wait for start.
  - ACCUM: accept pixel beats.
  - FLUSH: two cycles, drains the pipeline.
  - DONE: one cycle, publishes the result; then returns to IDLE.
- start in any state (including ACCUM/FLUSH):
  - Next cycle enters ACCUM.
  - Clears the internal running extrema and counter.
  - Published outputs are unchanged.
  - Pixel beats are accepted from the cycle after start.
- Beats with pix_valid outside ACCUM are ignored.
- Pipeline stage 1, on pix_valid&pix_hit in ACCUM, registers:
  - s = x+y, unsigned, COORD_W+1 bits.
  - d = x−y, two's complement, COORD_W+1 bits.
  - The x and y values.
- Pipeline stage 2 updates the running extrema:
  - TL = min s, BR = max s, TR = max d, BL = min d.
  - Strict compare: on ties the earliest pixel is kept.
  - The first hit of a frame initialises all four extrema.
- hit counter: increments per hit and saturates at all-ones (no wrap).
- pix_valid&frame_end in ACCUM:
  - That beat is still processed; the FSM then goes to FLUSH.
  - done asserts exactly 3 cycles after the frame_end beat.
- In DONE, corners, found and hit_count update in the same cycle as done (atomic):
  - If count ≥ MIN_HITS: found=1, corners = the extrema coordinates.
  - Otherwise: found=0, corners = defaults.
- Simultaneous start and frame_end: start wins; the frame is discarded and no done is produced.
- Asynchronous reset mid-frame: return to IDLE immediately with the reset values above; no done.

Optional Feature:
- Macro: CORNER_TRACKER_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in ACCUM.
  - On reaching TIMEOUT_CYCLES without frame_end, the FSM goes to DONE.
  - In that case found=0, corners = defaults, hit_count = the count reached so far, and done pulses.
  - Adds output timeout (1 bit): reset 0, set with that done, cleared at the next start.
- Not defined: ACCUM waits indefinitely; no timeout port exists.

Test Plan:
- Reset then idle 20 cycles -> done never asserts; corners = {192,144,192,624,832,624,832,144}; found=0.
- start; 4x4 hit blocks around (100,50), (90,400), (700,420), (710,60) (16 hits each, 64 total); frame_end on the last beat -> done exactly 3 cycles later; corners = TL (100,50), BL (90,403), BR (703,423), TR (713,60); found=1; hit_count=64.
- start; frame containing only 5 hits -> done pulses; found=0; corners = defaults; hit_count=5.
- Tie: hits at (10,20) then (20,10), both s=30 and the minimum -> TL=(10,20).
- Second start issued mid-frame, then a new frame -> only one done, and it reflects the second frame only.
- With CORNER_TRACKER_TIMEOUT_EN and TIMEOUT_CYCLES=100: start, then no frame_end -> done at cycle 100 of ACCUM; timeout=1; found=0.
